// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// and the MEM-stage load/store path. One transaction in flight at a time;
// load/store normally wins, but a streak counter forces a fetch grant after
// LS_STREAK back-to-back load/store grants while fetch is waiting.
module mem_port_arbiter #(
  parameter int AW        = 32,
  parameter int TIMEOUT   = 15,
  parameter int LS_STREAK = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_ack,
  output logic [31:0]   o_if_rdata,
  output logic          o_if_stall,
  input  logic          i_ls_req,
  input  logic          i_ls_we,
  input  logic [AW-1:0] i_ls_addr,
  input  logic [31:0]   i_ls_wdata,
  input  logic [3:0]    i_ls_bmask,
  output logic          o_ls_ack,
  output logic [31:0]   o_ls_rdata,
  output logic          o_ls_stall,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic [3:0]    o_mem_bmask,
  input  logic          i_mem_ack,
  input  logic [31:0]   i_mem_rdata,
  output logic          o_err
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, LS_BUSY, IF_DROP} state_t;

  // Latched memory command, driven straight onto the o_mem_* port.
  typedef struct packed {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    bmask;
  } mem_cmd_t;

  localparam logic [3:0] STREAK_MAX = 4'(LS_STREAK);
  // Abort fires on the TIMEOUT-th busy cycle without an ack.
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  tcnt_q, tcnt_d;
  mem_cmd_t    cmd_q, cmd_d;
  logic        if_ack_q, if_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        ls_ack_q, ls_ack_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic        err_q, err_d;

  logic mem_ack_v;
  logic to_hit;
  logic if_go;
  logic starve;

  // Qualified request/ack terms used by the arbiter.
  always_comb begin
    mem_ack_v = i_mem_ack & cmd_q.req;
    to_hit    = (tcnt_q == TO_LAST);
    if_go     = i_if_req & ~i_flush;
    starve    = (streak_q == STREAK_MAX) & if_go;
  end

  // Next-state, command latch, counters and response generation.
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    tcnt_d     = tcnt_q;
    cmd_d      = cmd_q;
    if_ack_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    ls_ack_d   = 1'b0;
    ls_rdata_d = ls_rdata_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (i_ls_req && !starve) begin
          state_d     = LS_BUSY;
          tcnt_d      = '0;
          cmd_d.req   = 1'b1;
          cmd_d.we    = i_ls_we;
          cmd_d.addr  = i_ls_addr;
          cmd_d.wdata = i_ls_wdata;
          cmd_d.bmask = i_ls_bmask;
          // Only a load/store that bypasses a waiting fetch counts toward starvation.
          if (!i_if_req)                    streak_d = '0;
          else if (streak_q != STREAK_MAX)  streak_d = streak_q + 4'd1;
        end else if (if_go) begin
          state_d     = IF_BUSY;
          tcnt_d      = '0;
          streak_d    = '0;
          cmd_d.req   = 1'b1;
          cmd_d.we    = 1'b0;
          cmd_d.addr  = i_if_addr;
          cmd_d.wdata = '0;
          cmd_d.bmask = 4'hF;
        end
      end
      IF_BUSY: begin
        if (mem_ack_v) begin
          state_d   = IDLE;
          cmd_d.req = 1'b0;
          // A flush coinciding with the ack swallows the response.
          if (!i_flush) begin
            if_ack_d   = 1'b1;
            if_rdata_d = i_mem_rdata;
          end
        end else if (to_hit) begin
          state_d   = IDLE;
          cmd_d.req = 1'b0;
          err_d     = 1'b1;
          if (!i_flush) begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end
        end else begin
          tcnt_d = tcnt_q + 8'd1;
          // Memory cannot be cancelled mid-access; wait it out, then discard.
          if (i_flush) state_d = IF_DROP;
        end
      end
      IF_DROP: begin
        if (mem_ack_v) begin
          state_d   = IDLE;
          cmd_d.req = 1'b0;
        end else if (to_hit) begin
          state_d   = IDLE;
          cmd_d.req = 1'b0;
          err_d     = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      LS_BUSY: begin
        if (mem_ack_v) begin
          state_d    = IDLE;
          cmd_d.req  = 1'b0;
          ls_ack_d   = 1'b1;
          ls_rdata_d = cmd_q.we ? 32'h0 : i_mem_rdata;
        end else if (to_hit) begin
          state_d    = IDLE;
          cmd_d.req  = 1'b0;
          err_d      = 1'b1;
          ls_ack_d   = 1'b1;
          ls_rdata_d = '0;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        cmd_d.req = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset drops any in-flight access.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      tcnt_q     <= '0;
      cmd_q      <= '0;
      if_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      ls_ack_q   <= 1'b0;
      ls_rdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      tcnt_q     <= tcnt_d;
      cmd_q      <= cmd_d;
      if_ack_q   <= if_ack_d;
      if_rdata_q <= if_rdata_d;
      ls_ack_q   <= ls_ack_d;
      ls_rdata_q <= ls_rdata_d;
      err_q      <= err_d;
    end
  end

  assign o_mem_req   = cmd_q.req;
  assign o_mem_we    = cmd_q.we;
  assign o_mem_addr  = cmd_q.addr;
  assign o_mem_wdata = cmd_q.wdata;
  assign o_mem_bmask = cmd_q.bmask;
  assign o_if_ack    = if_ack_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_ls_ack    = ls_ack_q;
  assign o_ls_rdata  = ls_rdata_q;
  assign o_err       = err_q;
  assign o_if_stall  = i_if_req & ~if_ack_q;
  assign o_ls_stall  = i_ls_req & ~ls_ack_q;

endmodule
